// File: rtl/input_filter.sv
// Multi-channel synchroniser + debouncer with hysteretic output and per-channel rise/fall pulses.
// Latency SYNC_STAGES+(FILTER_LEN-1)*TICK_DIV+1 .. SYNC_STAGES+FILTER_LEN*TICK_DIV edges; no backpressure.
module input_filter #(
  parameter int   N           = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   TICK_DIV    = 2048,
  parameter int   FILTER_LEN  = 3,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         tick
);

  localparam int          CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [31:0] CNT_MAX = 32'(TICK_DIV - 1);

  logic [CW-1:0]         cnt;
  logic                  wrap;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q [N];
  logic [FILTER_LEN-1:0] sh [N];
  logic [N-1:0]          s;
  logic [N-1:0]          out_nxt;

  // Full-width compare so TICK_DIV-1 is never truncated to the counter width.
  assign wrap = (32'(cnt) == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        sync_q[i] <= {SYNC_STAGES{RST_VAL}};
        sh[i]     <= {FILTER_LEN{RST_VAL}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], in[i]};
        if (tick) begin
          sh[i] <= {sh[i][FILTER_LEN-2:0], s[i]};
        end
      end
    end
  end

  // Mixed history holds the previous level, giving hysteresis.
  always_comb begin
    out_nxt = out;
    for (int i = 0; i < N; i++) begin
      if (&sh[i]) begin
        out_nxt[i] = 1'b1;
      end else if (~|sh[i]) begin
        out_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out  <= {N{RST_VAL}};
      rise <= '0;
      fall <= '0;
    end else begin
      out  <= out_nxt;
      rise <= out_nxt & ~out;
      fall <= ~out_nxt & out;
    end
  end

endmodule

// File: tb/tb_input_filter.sv
// Bench for input_filter: two configurations checked every edge against a run-length reference model.
module tb_input_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a, rstn_b;
  logic [1:0] in_a, in_b;
  logic [1:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
  logic       tick_a, tick_b;

  input_filter #(.N(2), .SYNC_STAGES(2), .TICK_DIV(4), .FILTER_LEN(3), .RST_VAL(1'b0)) u_main (
    .clk(clk), .rstn(rstn_a), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .tick(tick_a));

  input_filter #(.N(2), .SYNC_STAGES(2), .TICK_DIV(1), .FILTER_LEN(2), .RST_VAL(1'b1)) u_corner (
    .clk(clk), .rstn(rstn_b), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b), .tick(tick_b));

  int   checks = 0;
  int   errors = 0;
  int   td [2] = '{4, 1};
  int   fl [2] = '{3, 2};
  logic rv [2] = '{1'b0, 1'b1};

  // Reference state: synchroniser delay line, run length of equal samples, edge count since reset.
  logic [1:0] sq0 [2], sq1 [2], last [2], mout [2], mrise [2], mfall [2];
  logic       mtick [2];
  int         run [2][2];
  int         since [2];
  int         n_rise [2][2];
  int         n_fall [2][2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int got, input int lo, input int hi);
    checks++;
    assert (got >= lo && got <= hi) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic model_edge(input int d, input logic r, input logic [1:0] x);
    logic [1:0] nxt;
    if (!r) begin
      since[d] = 0;
      sq0[d]   = {2{rv[d]}};
      sq1[d]   = {2{rv[d]}};
      last[d]  = {2{rv[d]}};
      mout[d]  = {2{rv[d]}};
      mrise[d] = 2'b00;
      mfall[d] = 2'b00;
      mtick[d] = 1'b0;
      for (int ch = 0; ch < 2; ch++) run[d][ch] = fl[d];
    end else begin
      nxt = mout[d];
      for (int ch = 0; ch < 2; ch++) begin
        if (run[d][ch] >= fl[d]) nxt[ch] = last[d][ch];
      end
      if (mtick[d]) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (sq1[d][ch] == last[d][ch]) begin
            run[d][ch] = (run[d][ch] < fl[d]) ? run[d][ch] + 1 : fl[d];
          end else begin
            last[d][ch] = sq1[d][ch];
            run[d][ch]  = 1;
          end
        end
      end
      sq1[d]   = sq0[d];
      sq0[d]   = x;
      mrise[d] = nxt & ~mout[d];
      mfall[d] = ~nxt & mout[d];
      mout[d]  = nxt;
      since[d] = since[d] + 1;
      mtick[d] = ((since[d] % td[d]) == 0);
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 2; ch++) begin
        n_rise[d][ch] = 0;
        n_fall[d][ch] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, rstn_a, in_a);
    model_edge(1, rstn_b, in_b);
    #1;
    chk("main_ports", 32'({out_a, rise_a, fall_a, tick_a}), 32'({mout[0], mrise[0], mfall[0], mtick[0]}));
    chk("corner_ports", 32'({out_b, rise_b, fall_b, tick_b}), 32'({mout[1], mrise[1], mfall[1], mtick[1]}));
    for (int ch = 0; ch < 2; ch++) begin
      n_rise[0][ch] += int'(rise_a[ch]);
      n_fall[0][ch] += int'(fall_a[ch]);
      n_rise[1][ch] += int'(rise_b[ch]);
      n_fall[1][ch] += int'(fall_b[ch]);
    end
  endtask

  // lat = edges after the first edge that samples the new level, until out[ch] equals val.
  task automatic measure(input int d, input int ch, input logic val, output int lat);
    logic [1:0] o;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      o = (d == 0) ? out_a : out_b;
      if (o[ch] === val) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  initial begin
    int ticks_a;
    int ticks_b;
    int lat;
    int seen;

    rstn_a = 1'b0; rstn_b = 1'b0;
    in_a = 2'b11;  in_b = 2'b11;
    clear_counts();

    repeat (3) begin
      step();
      chk("rst_out_a", 32'(out_a), 32'(2'b00));
      chk("rst_pulses_a", 32'({rise_a, fall_a, tick_a}), 32'd0);
      chk("rst_out_b", 32'(out_b), 32'(2'b11));
    end

    rstn_a = 1'b1; rstn_b = 1'b1; in_a = 2'b00;
    ticks_a = 0; ticks_b = 0;
    repeat (20) begin
      step();
      ticks_a += int'(tick_a);
      ticks_b += int'(tick_b);
    end
    chk("tick_count_div4", 32'(ticks_a), 32'd5);
    chk("tick_count_div1", 32'(ticks_b), 32'd20);

    // Single-channel step
    clear_counts();
    in_a = 2'b01;
    measure(0, 0, 1'b1, lat);
    chk_range("rise_latency", lat, 11, 14);
    repeat (10) step();
    chk("rise_once", 32'(n_rise[0][0]), 32'd1);
    chk("no_fall_on_rise", 32'(n_fall[0][0]), 32'd0);
    chk("ch1_untouched", 32'(out_a), 32'(2'b01));
    chk("ch1_no_rise", 32'(n_rise[0][1]), 32'd0);

    // Short low glitch, then toggling below the filter window
    clear_counts();
    in_a[0] = 1'b0;
    repeat (7) step();
    in_a[0] = 1'b1;
    repeat (20) step();
    chk("glitch_out_held", 32'(out_a[0]), 32'd1);
    chk("glitch_no_fall", 32'(n_fall[0][0]), 32'd0);
    for (int i = 0; i < 40; i++) begin
      in_a[0] = ((i / 4) % 2) == 1;
      step();
    end
    in_a[0] = 1'b1;
    repeat (12) step();
    chk("toggle_out_held", 32'(out_a[0]), 32'd1);
    chk("toggle_no_pulses", 32'(n_fall[0][0] + n_rise[0][0]), 32'd0);

    in_a[0] = 1'b0;
    measure(0, 0, 1'b0, lat);
    chk_range("fall_latency", lat, 11, 14);
    repeat (10) step();
    chk("fall_once", 32'(n_fall[0][0]), 32'd1);

    // Both channels step together
    in_a = 2'b00;
    repeat (20) step();
    clear_counts();
    in_a = 2'b11;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (rise_a !== 2'b00) begin
        seen = 1;
        break;
      end
    end
    chk("simul_seen", 32'(seen), 32'd1);
    chk("simul_rise", 32'(rise_a), 32'(2'b11));
    repeat (10) step();
    chk("simul_once", 32'({n_rise[0][1][7:0], n_rise[0][0][7:0]}), 32'h0101);

    // Reset mid-operation with out high
    clear_counts();
    rstn_a = 1'b0;
    step();
    chk("midrst_out", 32'(out_a), 32'(2'b00));
    chk("midrst_no_fall", 32'(fall_a), 32'd0);
    rstn_a = 1'b1;
    measure(0, 0, 1'b1, lat);
    chk_range("midrst_rise_latency", lat, 11, 14);
    chk("midrst_rise_both", 32'(rise_a), 32'(2'b11));
    repeat (5) step();
    chk("midrst_fall_count", 32'(n_fall[0][0] + n_fall[0][1]), 32'd0);

    // Corner config: single-cycle low rejected, two-cycle low passes
    clear_counts();
    in_b[0] = 1'b0;
    step();
    in_b[0] = 1'b1;
    repeat (6) step();
    chk("corner_glitch_out", 32'(out_b), 32'(2'b11));
    chk("corner_glitch_no_fall", 32'(n_fall[1][0]), 32'd0);
    lat = -1;
    in_b[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) in_b[0] = 1'b1;
      step();
      if (out_b[0] === 1'b0 && lat < 0) lat = k - 1;
    end
    chk_range("corner_fall_latency", lat, 4, 4);
    chk("corner_fall_once", 32'(n_fall[1][0]), 32'd1);

    // Randomised traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) in_a = 2'($urandom);
      if ($urandom_range(0, 2) == 0) in_b = 2'($urandom);
      rstn_a = ($urandom_range(0, 599) != 0);
      rstn_b = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
